// File: rtl/blackjack_pkg.sv
// Shared blackjack definitions: draw FSM encoding, legal card range and the
// single-deck shoe contents used by card_draw_arbiter.
package blackjack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STEP    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_t;

  localparam int CARD_MIN   = 2;
  localparam int CARD_MAX   = 11;
  localparam int N_VALUES   = CARD_MAX - CARD_MIN + 1;
  localparam int SHOE_TOTAL = 52;
  localparam int COUNT_W    = 5;

  // Tens cover 10/J/Q/K, hence four times the count of every other value.
  function automatic logic [COUNT_W-1:0] shoe_count(input int value);
    return (value == 10) ? COUNT_W'(16) : COUNT_W'(4);
  endfunction

endpackage

// File: rtl/card_draw_arbiter_rr_arbiter.sv
// Round-robin requester pick for card_draw_arbiter. The search is combinational;
// the priority pointer only moves past a winner once that winner acks its card.
module rr_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  input  logic [N_REQ-1:0] adv_gnt,
  output logic [N_REQ-1:0] grant
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (req[idx] && (grant == '0)) begin
        grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (adv_gnt[i]) begin
          ptr_d = PW'((i + 1) % N_REQ);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/card_draw_arbiter.sv
// Blackjack card-draw arbiter: grants one requester, steps the RNG until a legal
// card arrives and holds it until acked. Define CARD_SHOE_EN for a finite single-deck shoe.
module card_draw_arbiter
  import blackjack_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int CARD_W   = 5,
  parameter int WAIT_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [CARD_W-1:0] card,
  output logic              card_valid,
  input  logic              card_ack,
  output logic              rng_step,
  input  logic [CARD_W-1:0] rng_card,
  input  logic              rng_valid,
  output logic              err_timeout,
  output logic              busy,
  output logic [5:0]        draws_total,
  input  logic              shoe_reset,
  output logic              shoe_empty
);

  localparam int WCW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WCW-1:0]    WAIT_LAST = WCW'(WAIT_MAX - 1);
  localparam logic [CARD_W-1:0] CMIN      = CARD_W'(CARD_MIN);
  localparam logic [CARD_W-1:0] CMAX      = CARD_W'(CARD_MAX);

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [CARD_W-1:0] card_q, card_d;
  logic              card_valid_q, card_valid_d;
  logic              rng_step_q, rng_step_d;
  logic              err_timeout_q, err_timeout_d;
  logic              busy_q, busy_d;
  logic [5:0]        draws_q, draws_d;
  logic [WCW-1:0]    wait_q, wait_d;

  logic [N_REQ-1:0]  arb_grant;
  logic              arb_advance;
  logic              in_range;
  logic              card_ok;
  logic              shoe_block;

  assign in_range    = (rng_card >= CMIN) && (rng_card <= CMAX);
  assign arb_advance = (state_q == ST_DELIVER) && card_ack;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr_arbiter (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .advance(arb_advance),
    .adv_gnt(gnt_q),
    .grant  (arb_grant)
  );

`ifdef CARD_SHOE_EN
  localparam int IW = $clog2(N_VALUES);

  logic [COUNT_W-1:0] cnt_q [N_VALUES];
  logic [COUNT_W-1:0] cnt_d [N_VALUES];
  logic [5:0]         left_q, left_d;
  logic               empty_q, empty_d;
  logic [IW-1:0]      rng_idx;
  logic [IW-1:0]      card_idx;

  assign rng_idx    = IW'(rng_card - CMIN);
  assign card_idx   = IW'(card_q - CMIN);
  assign card_ok    = in_range && (cnt_q[rng_idx] != '0);
  assign shoe_block = empty_q;
  assign shoe_empty = empty_q;

  // Counts drop when the card is consumed, so only one card is ever in flight.
  always_comb begin
    cnt_d   = cnt_q;
    left_d  = left_q;
    empty_d = empty_q;
    if ((state_q == ST_DELIVER) && card_ack) begin
      cnt_d[card_idx] = cnt_q[card_idx] - COUNT_W'(1);
      left_d          = left_q - 6'd1;
      empty_d         = (left_q == 6'd1);
    end
    if ((state_q == ST_IDLE) && shoe_reset) begin
      for (int i = 0; i < N_VALUES; i++) begin
        cnt_d[i] = shoe_count(i + CARD_MIN);
      end
      left_d  = 6'(SHOE_TOTAL);
      empty_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_VALUES; i++) begin
        cnt_q[i] <= shoe_count(i + CARD_MIN);
      end
      left_q  <= 6'(SHOE_TOTAL);
      empty_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      empty_q <= empty_d;
    end
  end
`else
  logic unused_shoe_reset;

  assign unused_shoe_reset = shoe_reset;
  assign card_ok           = in_range;
  assign shoe_block        = 1'b0;
  assign shoe_empty        = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    card_d        = card_q;
    card_valid_d  = card_valid_q;
    err_timeout_d = 1'b0;
    draws_d       = draws_q;
    wait_d        = wait_q;
    case (state_q)
      ST_IDLE: begin
        if ((|req) && !shoe_block) begin
          gnt_d   = arb_grant;
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rng_valid) begin
          if (card_ok) begin
            card_d       = rng_card;
            card_valid_d = 1'b1;
            state_d      = ST_DELIVER;
          end else begin
            state_d = ST_STEP;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = ST_STEP;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      ST_DELIVER: begin
        if (card_ack) begin
          draws_d      = draws_q + 6'd1;
          gnt_d        = '0;
          card_d       = '0;
          card_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered so the pulse coincides with the STEP cycle itself.
    rng_step_d = (state_d == ST_STEP);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      card_q        <= '0;
      card_valid_q  <= 1'b0;
      rng_step_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      draws_q       <= '0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      card_q        <= card_d;
      card_valid_q  <= card_valid_d;
      rng_step_q    <= rng_step_d;
      err_timeout_q <= err_timeout_d;
      busy_q        <= busy_d;
      draws_q       <= draws_d;
      wait_q        <= wait_d;
    end
  end

  assign gnt         = gnt_q;
  assign card        = card_q;
  assign card_valid  = card_valid_q;
  assign rng_step    = rng_step_q;
  assign err_timeout = err_timeout_q;
  assign busy        = busy_q;
  assign draws_total = draws_q;

endmodule

// File: tb/tb_card_draw_arbiter.sv
// Directed bench for card_draw_arbiter (default parameters); the shoe scenario
// is only compiled when CARD_SHOE_EN is defined.
module tb_card_draw_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [4:0] card;
  logic       card_valid;
  logic       card_ack;
  logic       rng_step;
  logic [4:0] rng_card;
  logic       rng_valid;
  logic       err_timeout;
  logic       busy;
  logic [5:0] draws_total;
  logic       shoe_reset;
  logic       shoe_empty;

  int n_checks = 0;
  int n_fail   = 0;

  card_draw_arbiter #(
    .N_REQ(3),
    .CARD_W(5),
    .WAIT_MAX(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .card       (card),
    .card_valid (card_valid),
    .card_ack   (card_ack),
    .rng_step   (rng_step),
    .rng_card   (rng_card),
    .rng_valid  (rng_valid),
    .err_timeout(err_timeout),
    .busy       (busy),
    .draws_total(draws_total),
    .shoe_reset (shoe_reset),
    .shoe_empty (shoe_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst        = 1'b1;
    req        = '0;
    card_ack   = 1'b0;
    rng_card   = '0;
    rng_valid  = 1'b0;
    shoe_reset = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Full draw with fixed timing: grant, step, one RNG value, deliver, ack.
  task automatic do_draw(input logic [2:0] r, input logic [4:0] c,
                         output logic [2:0] g, output logic [4:0] cv, output logic v);
    req = r;
    step();
    g = gnt;
    step();
    rng_valid = 1'b1;
    rng_card  = c;
    step();
    rng_valid = 1'b0;
    cv        = card;
    v         = card_valid;
    card_ack  = 1'b1;
    step();
    card_ack = 1'b0;
    req      = '0;
  endtask

  task automatic test_reset;
    apply_reset();
    n_checks++;
    if ({gnt, card, card_valid, rng_step, err_timeout, busy, draws_total, shoe_empty} !== 19'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got gnt=%b card=%0d cv=%b step=%b to=%b busy=%b draws=%0d empty=%b, want all 0",
               gnt, card, card_valid, rng_step, err_timeout, busy, draws_total, shoe_empty);
    end
  endtask

  task automatic test_single_draw;
    logic [2:0] g;
    logic [4:0] cv;
    logic v;
    apply_reset();
    req = 3'b001;
    step();
    n_checks++;
    if ({gnt, rng_step, busy} !== {3'b001, 1'b1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL single_cycle1: got gnt=%b step=%b busy=%b, want 001 1 1", gnt, rng_step, busy);
    end
    step();
    n_checks++;
    if ({rng_step, card_valid} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL single_cycle2: got step=%b cv=%b, want 0 0", rng_step, card_valid);
    end
    rng_valid = 1'b1;
    rng_card  = 5'd7;
    step();
    rng_valid = 1'b0;
    rng_card  = 5'd3;
    n_checks++;
    if ({card_valid, card} !== {1'b1, 5'd7}) begin
      n_fail++;
      $display("[TB] FAIL single_cycle3: got cv=%b card=%0d, want 1 7", card_valid, card);
    end
    step();
    n_checks++;
    if ({card_valid, card, gnt} !== {1'b1, 5'd7, 3'b001}) begin
      n_fail++;
      $display("[TB] FAIL single_hold: got cv=%b card=%0d gnt=%b, want 1 7 001", card_valid, card, gnt);
    end
    card_ack = 1'b1;
    step();
    card_ack = 1'b0;
    req      = '0;
    n_checks++;
    if ({draws_total, gnt, card_valid, busy} !== {6'd1, 3'b000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL single_ack: got draws=%0d gnt=%b cv=%b busy=%b, want 1 000 0 0",
               draws_total, gnt, card_valid, busy);
    end
    do_draw(3'b111, 5'd8, g, cv, v);
    n_checks++;
    if (g !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL pointer_after_ack: got gnt=%b, want 010", g);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0] g;
    logic [4:0] cv;
    logic v;
    logic [2:0] exp_g [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_draw(3'b111, 5'(3 + i), g, cv, v);
      n_checks++;
      if ({g, cv, v} !== {exp_g[i], 5'(3 + i), 1'b1}) begin
        n_fail++;
        $display("[TB] FAIL rr_grant_%0d: got gnt=%b card=%0d cv=%b, want %b %0d 1",
                 i, g, cv, v, exp_g[i], 3 + i);
      end
    end
  endtask

  task automatic test_redraw;
    int steps;
    logic [4:0] bad [4];
    bad = '{5'd0, 5'd14, 5'd1, 5'd12};
    apply_reset();
    req = 3'b010;
    step();
    steps = int'(rng_step);
    for (int i = 0; i < 4; i++) begin
      step();
      rng_valid = 1'b1;
      rng_card  = bad[i];
      step();
      rng_valid = 1'b0;
      steps += int'(rng_step);
      n_checks++;
      if ({rng_step, card_valid, gnt} !== {1'b1, 1'b0, 3'b010}) begin
        n_fail++;
        $display("[TB] FAIL redraw_%0d: got step=%b cv=%b gnt=%b, want 1 0 010",
                 bad[i], rng_step, card_valid, gnt);
      end
    end
    step();
    rng_valid = 1'b1;
    rng_card  = 5'd9;
    step();
    rng_valid = 1'b0;
    n_checks++;
    if ({card_valid, card, steps} !== {1'b1, 5'd9, 32'd5}) begin
      n_fail++;
      $display("[TB] FAIL redraw_deliver: got cv=%b card=%0d steps=%0d, want 1 9 5", card_valid, card, steps);
    end
    card_ack = 1'b1;
    step();
    card_ack = 1'b0;
    req      = '0;
  endtask

  task automatic test_boundary_cards;
    logic [2:0] g;
    logic [4:0] cv;
    logic v;
    apply_reset();
    do_draw(3'b001, 5'd2, g, cv, v);
    n_checks++;
    if ({cv, v} !== {5'd2, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL card_min: got card=%0d cv=%b, want 2 1", cv, v);
    end
    do_draw(3'b001, 5'd11, g, cv, v);
    n_checks++;
    if ({cv, v, draws_total} !== {5'd11, 1'b1, 6'd2}) begin
      n_fail++;
      $display("[TB] FAIL card_max: got card=%0d cv=%b draws=%0d, want 11 1 2", cv, v, draws_total);
    end
  endtask

  task automatic test_timeout;
    int early;
    apply_reset();
    req = 3'b001;
    step();
    step();
    early = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (err_timeout || rng_step) early++;
    end
    n_checks++;
    if (early !== 0) begin
      n_fail++;
      $display("[TB] FAIL timeout_early: got %0d cycles with pulse, want 0", early);
    end
    step();
    n_checks++;
    if ({err_timeout, rng_step, gnt} !== {1'b1, 1'b1, 3'b001}) begin
      n_fail++;
      $display("[TB] FAIL timeout_pulse: got to=%b step=%b gnt=%b, want 1 1 001", err_timeout, rng_step, gnt);
    end
    step();
    n_checks++;
    if ({err_timeout, rng_step, gnt} !== {1'b0, 1'b0, 3'b001}) begin
      n_fail++;
      $display("[TB] FAIL timeout_one_cycle: got to=%b step=%b gnt=%b, want 0 0 001", err_timeout, rng_step, gnt);
    end
    rng_valid = 1'b1;
    rng_card  = 5'd5;
    step();
    rng_valid = 1'b0;
    n_checks++;
    if ({card_valid, card} !== {1'b1, 5'd5}) begin
      n_fail++;
      $display("[TB] FAIL timeout_retry_card: got cv=%b card=%0d, want 1 5", card_valid, card);
    end
    card_ack = 1'b1;
    step();
    card_ack = 1'b0;
    req      = '0;
  endtask

  task automatic test_drop_and_stray_ack;
    apply_reset();
    card_ack = 1'b1;
    step();
    n_checks++;
    if ({draws_total, busy} !== {6'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL ack_in_idle: got draws=%0d busy=%b, want 0 0", draws_total, busy);
    end
    req = 3'b100;
    step();
    req = 3'b000;
    step();
    step();
    n_checks++;
    if ({draws_total, gnt, busy, card_valid} !== {6'd0, 3'b100, 1'b1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL ack_in_wait: got draws=%0d gnt=%b busy=%b cv=%b, want 0 100 1 0",
               draws_total, gnt, busy, card_valid);
    end
    card_ack  = 1'b0;
    rng_valid = 1'b1;
    rng_card  = 5'd6;
    step();
    rng_valid = 1'b0;
    n_checks++;
    if ({gnt, card_valid, card} !== {3'b100, 1'b1, 5'd6}) begin
      n_fail++;
      $display("[TB] FAIL dropped_req_deliver: got gnt=%b cv=%b card=%0d, want 100 1 6", gnt, card_valid, card);
    end
    card_ack = 1'b1;
    step();
    card_ack = 1'b0;
    n_checks++;
    if ({gnt, draws_total, busy} !== {3'b000, 6'd1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL dropped_req_ack: got gnt=%b draws=%0d busy=%b, want 000 1 0", gnt, draws_total, busy);
    end
  endtask

  task automatic test_reset_in_deliver;
    logic [2:0] g;
    logic [4:0] cv;
    logic v;
    apply_reset();
    do_draw(3'b001, 5'd10, g, cv, v);
    req = 3'b010;
    step();
    step();
    rng_valid = 1'b1;
    rng_card  = 5'd4;
    step();
    rng_valid = 1'b0;
    req       = '0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({gnt, card, card_valid, rng_step, err_timeout, busy, draws_total} !== 18'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_in_deliver: got gnt=%b card=%0d cv=%b step=%b to=%b busy=%b draws=%0d, want all 0",
               gnt, card, card_valid, rng_step, err_timeout, busy, draws_total);
    end
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if ({busy, gnt, card_valid} !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_back_idle: got busy=%b gnt=%b cv=%b, want 0 000 0", busy, gnt, card_valid);
    end
  endtask

`ifndef CARD_SHOE_EN
  task automatic test_draws_wrap;
    logic [2:0] g;
    logic [4:0] cv;
    logic v;
    apply_reset();
    shoe_reset = 1'b1;
    for (int i = 0; i < 63; i++) begin
      do_draw(3'b001, 5'(2 + (i % 10)), g, cv, v);
    end
    shoe_reset = 1'b0;
    n_checks++;
    if ({draws_total, shoe_empty} !== {6'd63, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL draws_63: got draws=%0d empty=%b, want 63 0", draws_total, shoe_empty);
    end
    do_draw(3'b001, 5'd3, g, cv, v);
    n_checks++;
    if (draws_total !== 6'd0) begin
      n_fail++;
      $display("[TB] FAIL draws_wrap: got %0d, want 0", draws_total);
    end
  endtask
`else
  task automatic test_shoe;
    logic [2:0] g;
    logic [4:0] cv;
    logic v;
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      do_draw(3'b001, 5'd11, g, cv, v);
      if ({cv, v} !== {5'd11, 1'b1}) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("[TB] FAIL shoe_four_aces: got %0d bad deliveries, want 0", bad);
    end
    req = 3'b001;
    step();
    step();
    rng_valid = 1'b1;
    rng_card  = 5'd11;
    step();
    rng_valid = 1'b0;
    n_checks++;
    if ({rng_step, card_valid} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL shoe_fifth_ace: got step=%b cv=%b, want 1 0", rng_step, card_valid);
    end
    step();
    rng_valid = 1'b1;
    rng_card  = 5'd10;
    step();
    rng_valid = 1'b0;
    card_ack  = 1'b1;
    step();
    card_ack = 1'b0;
    for (int i = 0; i < 15; i++) do_draw(3'b001, 5'd10, g, cv, v);
    for (int val = 2; val <= 9; val++) begin
      for (int k = 0; k < 4; k++) do_draw(3'b001, 5'(val), g, cv, v);
    end
    n_checks++;
    if ({shoe_empty, draws_total} !== {1'b1, 6'd52}) begin
      n_fail++;
      $display("[TB] FAIL shoe_empty: got empty=%b draws=%0d, want 1 52", shoe_empty, draws_total);
    end
    req = 3'b001;
    step();
    n_checks++;
    if ({gnt, busy} !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL shoe_no_grant: got gnt=%b busy=%b, want 000 0", gnt, busy);
    end
    req        = '0;
    shoe_reset = 1'b1;
    step();
    shoe_reset = 1'b0;
    req        = 3'b001;
    step();
    n_checks++;
    if ({shoe_empty, gnt} !== {1'b0, 3'b001}) begin
      n_fail++;
      $display("[TB] FAIL shoe_refill: got empty=%b gnt=%b, want 0 001", shoe_empty, gnt);
    end
    req = '0;
  endtask
`endif

  initial begin
    rst        = 1'b1;
    req        = '0;
    card_ack   = 1'b0;
    rng_card   = '0;
    rng_valid  = 1'b0;
    shoe_reset = 1'b0;
    #1;
    test_reset();
    test_single_draw();
    test_round_robin();
    test_redraw();
    test_boundary_cards();
    test_timeout();
    test_drop_and_stray_ack();
    test_reset_in_deliver();
`ifndef CARD_SHOE_EN
    test_draws_wrap();
`else
    test_shoe();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/card_draw_arbiter.md
CARD_DRAW_ARBITER -- requirements
Module: card_draw_arbiter

Interface
REQ-001 Parameter: N_REQ, default 3, number of card requesters (player, dealer, double).
REQ-002 Parameter: CARD_W, default 5, card value width.
REQ-003 Parameter: WAIT_MAX, default 8, maximum cycles spent waiting for rng_valid.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 Port clk  in  1  system clock.
REQ-006 Port rst  in  1  async active-high reset.
REQ-007 Port req  in  N_REQ  per-requester draw request, level, held until card_ack.
REQ-008 Port gnt  out  N_REQ  one-hot grant, held from STEP through DELIVER.
REQ-009 Port card  out  CARD_W  delivered card value, valid only when card_valid=1.
REQ-010 Port card_valid  out  1  card available to the granted requester.
REQ-011 Port card_ack  in  1  granted requester consumed the card.
REQ-012 Port rng_step  out  1  one-cycle pulse requesting a fresh RNG card.
REQ-013 Port rng_card  in  CARD_W  RNG card value.
REQ-014 Port rng_valid  in  1  rng_card is fresh.
REQ-015 Port err_timeout  out  1  one-cycle pulse when the WAIT_MAX limit expires.
REQ-016 Port busy  out  1  high in any state other than IDLE.
REQ-017 Port draws_total  out  6  count of delivered cards, wraps 63->0.
REQ-018 Port shoe_reset  in  1  refills the shoe.
REQ-019 Port shoe_empty  out  1  shoe exhausted.

Function
REQ-020 FSM states: IDLE, STEP, WAIT, DELIVER.
REQ-021 IDLE: when any req bit is high, register the round-robin winner in gnt and enter STEP.
REQ-022 Arbitration:
- Search starts at the requester after the last acked winner; priority pointer resets to index 0.
- Pointer advances only on card_ack.
REQ-023 STEP: rng_step=1 for exactly one cycle, then enter WAIT; the wait counter clears.
REQ-024 WAIT, rng_valid=1 with rng_card in 2..11: latch card, enter DELIVER.
REQ-025 WAIT, rng_valid=1 with rng_card outside 2..11: discard the value, return to STEP.
REQ-026 WAIT, WAIT_MAX cycles without rng_valid: pulse err_timeout, return to STEP (retry); gnt holds.
REQ-027 DELIVER: card_valid=1 and card stable until card_ack.
REQ-028 On card_ack: draws_total+1, gnt clears, enter IDLE; a new grant is possible no earlier than the next cycle.
REQ-029 Latency: req high in IDLE at cycle 0; gnt at cycle 1; rng_step at cycle 1; rng_valid at cycle 2 gives card_valid at cycle 3.
REQ-030 Requests dropped after grant are ignored; the grant holds until card_ack.
REQ-031 card_ack outside DELIVER is ignored.
REQ-032 Each delivered card comes from its own rng_step; no RNG value is delivered twice.

Reset
REQ-033 rst forces IDLE immediately; any in-flight card is discarded.
REQ-034 Values under rst: gnt=0, card=0, card_valid=0, rng_step=0, err_timeout=0, busy=0, draws_total=0, shoe_empty=0, round-robin pointer=0, shoe full.

Configuration
REQ-035 Macro CARD_SHOE_EN: compiles in a single-deck shoe.
- Shoe contents: 4 each of values 2..9, 16 of value 10, 4 of value 11.
REQ-036 With CARD_SHOE_EN: an rng_card value whose count is 0 is treated like REQ-025 (redraw); each delivered card decrements its count.
REQ-037 With CARD_SHOE_EN, after 52 deliveries:
- shoe_empty=1 and IDLE issues no grants.
- shoe_reset in IDLE refills all counts and clears shoe_empty; shoe_reset in other states is ignored.
REQ-038 Without CARD_SHOE_EN: infinite deck, shoe_empty tied 0, shoe_reset ignored, no count storage.

Structure
REQ-039 Shared package (blackjack_pkg): FSM state encoding, CARD_MIN=2, CARD_MAX=11, per-value shoe counts.
REQ-040 One sub-module: rr_arbiter (N_REQ-wide round-robin pick, combinational, with registered pointer).

Verification
REQ-041 req=001, rng_valid a cycle after rng_step with card 7: gnt=001, card_valid at cycle 3 with card=7; ack gives draws_total=1.
REQ-042 req=111 held, ack every card: grant order 001,010,100,001.
REQ-043 rng_card=0 then 14 then 9: two rng_step re-pulses, delivered card=9.
REQ-044 rng_valid withheld 8 cycles: err_timeout pulse, new rng_step, gnt unchanged.
REQ-045 rst asserted in DELIVER: all outputs 0 in the same cycle, IDLE, draws_total=0.
REQ-046 CARD_SHOE_EN, RNG forced to 11: four aces delivered, then a fifth 11 triggers a redraw; after 52 deliveries shoe_empty=1 until shoe_reset.
